ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_pkg.sv | 90 +++++++++
 rtl/ctrl_seq_prio_enc.sv | 32 +++
 rtl/ctrl_seq.sv | 181 ++++++++++++++++++
 tb/tb_ctrl_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared decode tables, control-flag bundle and FSM encodings for ctrl_seq.
package ctrl_seq_pkg;

   typedef enum logic [1:0] {
      MODE_ARITH  = 2'b00,
      MODE_MEM    = 2'b01,
      MODE_BRANCH = 2'b10,
      MODE_BLOCK  = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_e;

   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_TST = 4'b1000;

   localparam logic [3:0] MOV_EXE = 4'b0001;
   localparam logic [3:0] MVN_EXE = 4'b1001;
   localparam logic [3:0] ADD_EXE = 4'b0010;
   localparam logic [3:0] ADC_EXE = 4'b0011;
   localparam logic [3:0] SUB_EXE = 4'b0100;
   localparam logic [3:0] SBC_EXE = 4'b0101;
   localparam logic [3:0] AND_EXE = 4'b0110;
   localparam logic [3:0] ORR_EXE = 4'b0111;
   localparam logic [3:0] EOR_EXE = 4'b1000;
   localparam logic [3:0] TST_EXE = 4'b0110;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic wb_en;
      logic s_out;
      logic b;
      logic is_ldr;
   } flags_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] exe;
      logic       wb;
   } arith_dec_t;

   function automatic arith_dec_t decode_arith(input logic [3:0] op);
      arith_dec_t d;
      d = '0;
      d.valid = 1'b1;
      case (op)
         OP_MOV:  begin d.exe = MOV_EXE; d.wb = 1'b1; end
         OP_MVN:  begin d.exe = MVN_EXE; d.wb = 1'b1; end
         OP_ADD:  begin d.exe = ADD_EXE; d.wb = 1'b1; end
         OP_ADC:  begin d.exe = ADC_EXE; d.wb = 1'b1; end
         OP_SUB:  begin d.exe = SUB_EXE; d.wb = 1'b1; end
         OP_SBC:  begin d.exe = SBC_EXE; d.wb = 1'b1; end
         OP_AND:  begin d.exe = AND_EXE; d.wb = 1'b1; end
         OP_ORR:  begin d.exe = ORR_EXE; d.wb = 1'b1; end
         OP_EOR:  begin d.exe = EOR_EXE; d.wb = 1'b1; end
         OP_CMP:  d.exe = SUB_EXE;
         OP_TST:  d.exe = TST_EXE;
         default: d = '0;
      endcase
      return d;
   endfunction

   // Memory accesses and block beats share one flag pattern, keyed on load/store.
   function automatic flags_t mem_flags(input logic load);
      flags_t f;
      f = '0;
      f.s_out = load;
      if (load) begin
         f.mem_read = 1'b1;
         f.wb_en    = 1'b1;
         f.is_ldr   = 1'b1;
      end else begin
         f.mem_write = 1'b1;
      end
      return f;
   endfunction

endpackage

// File: rtl/ctrl_seq_prio_enc.sv
// Lowest-set-bit encoder over a register mask, plus the mask with that bit cleared.
module prio_enc
   import ctrl_seq_pkg::*;
#(
   parameter int unsigned NREG = 16,
   parameter int unsigned RI_W = $clog2(NREG)
) (
   input  logic [NREG-1:0] mask,
   output logic [RI_W-1:0] idx,
   output logic            any,
   output logic            more,
   output logic [NREG-1:0] rest
);

   logic hit;

   always_comb begin
      idx = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (!hit && mask[i]) begin
            idx = RI_W'(i);
            hit = 1'b1;
         end
      end
   end

   assign rest = mask & (mask - NREG'(1));
   assign any  = |mask;
   assign more = |rest;

endmodule

// File: rtl/ctrl_seq.sv
// Registered instruction controller: single-cycle decode plus a block-transfer
// sequencer that walks a register mask one beat per unstalled cycle.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int unsigned NREG  = 16,
   parameter int unsigned CMD_W = 4,
   parameter int unsigned RI_W  = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             S,
   input  logic [1:0]       mode,
   input  logic [3:0]       op_code,
   input  logic [NREG-1:0]  reg_list,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   output logic [CMD_W-1:0] exe_cmd,
   output logic             mem_read,
   output logic             mem_write,
   output logic             wb_en,
   output logic             S_out,
   output logic             B,
   output logic             is_ldr,
   output logic [RI_W-1:0]  xfer_reg,
   output logic [RI_W-1:0]  xfer_ofs,
   output logic             busy
);

   state_e            state_q, state_d;
   logic [NREG-1:0]   mask_q, mask_d;
   logic              load_q, load_d;
   logic              valid_q, valid_d;
   logic [CMD_W-1:0]  exe_q, exe_d;
   flags_t            flags_q, flags_d;
   logic [RI_W-1:0]   reg_q, reg_d;
   logic [RI_W-1:0]   ofs_q, ofs_d;

   logic [NREG-1:0]   enc_mask;
   logic [RI_W-1:0]   enc_idx;
   logic              enc_any;
   logic              enc_more;
   logic [NREG-1:0]   enc_rest;
   logic              accept;
   arith_dec_t        dec;

   // One encoder serves both the accepting instruction and the in-flight mask.
   assign enc_mask = (state_q == ST_XFER) ? mask_q : reg_list;

   prio_enc #(
      .NREG (NREG),
      .RI_W (RI_W)
   ) u_prio_enc (
      .mask (enc_mask),
      .idx  (enc_idx),
      .any  (enc_any),
      .more (enc_more),
      .rest (enc_rest)
   );

   assign dec    = decode_arith(op_code);
   assign accept = in_valid && !stall && !flush && (state_q == ST_IDLE);
   assign busy   = (state_q == ST_XFER) ||
                   (accept && (mode_e'(mode) == MODE_BLOCK) && enc_more);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      load_d  = load_q;
      valid_d = valid_q;
      exe_d   = exe_q;
      flags_d = flags_q;
      reg_d   = reg_q;
      ofs_d   = ofs_q;

      if (flush) begin
         state_d = ST_IDLE;
         mask_d  = '0;
         load_d  = 1'b0;
         valid_d = 1'b0;
         exe_d   = '0;
         flags_d = '0;
         reg_d   = '0;
         ofs_d   = '0;
      end else if (!stall) begin
         case (state_q)
            ST_IDLE: begin
               valid_d = 1'b0;
               exe_d   = '0;
               flags_d = '0;
               reg_d   = '0;
               ofs_d   = '0;
               mask_d  = '0;
               if (in_valid) begin
                  valid_d = 1'b1;
                  case (mode_e'(mode))
                     MODE_ARITH: begin
                        if (dec.valid) begin
                           exe_d         = CMD_W'(dec.exe);
                           flags_d.wb_en = dec.wb;
                           flags_d.s_out = S;
                        end
                     end
                     MODE_MEM: begin
                        exe_d   = CMD_W'(ADD_EXE);
                        flags_d = mem_flags(S);
                     end
                     MODE_BRANCH: begin
                        flags_d.b = 1'b1;
                     end
                     MODE_BLOCK: begin
                        if (enc_any) begin
                           exe_d   = CMD_W'(ADD_EXE);
                           flags_d = mem_flags(S);
                           reg_d   = enc_idx;
                           load_d  = S;
                           if (enc_more) begin
                              mask_d  = enc_rest;
                              state_d = ST_XFER;
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_XFER: begin
               valid_d = 1'b1;
               exe_d   = CMD_W'(ADD_EXE);
               flags_d = mem_flags(load_q);
               reg_d   = enc_idx;
               ofs_d   = ofs_q + RI_W'(1);
               mask_d  = enc_rest;
               if (!enc_more) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               mask_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         load_q  <= 1'b0;
         valid_q <= 1'b0;
         exe_q   <= '0;
         flags_q <= '0;
         reg_q   <= '0;
         ofs_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         load_q  <= load_d;
         valid_q <= valid_d;
         exe_q   <= exe_d;
         flags_q <= flags_d;
         reg_q   <= reg_d;
         ofs_q   <= ofs_d;
      end
   end

   assign out_valid = valid_q;
   assign exe_cmd   = exe_q;
   assign mem_read  = flags_q.mem_read;
   assign mem_write = flags_q.mem_write;
   assign wb_en     = flags_q.wb_en;
   assign S_out     = flags_q.s_out;
   assign B         = flags_q.b;
   assign is_ldr    = flags_q.is_ldr;
   assign xfer_reg  = reg_q;
   assign xfer_ofs  = ofs_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: each driven cycle queues the control word
// expected after the next rising edge; a monitor pops and compares it.
module tb_ctrl_seq;
   import ctrl_seq_pkg::*;

   localparam int unsigned NREG  = 16;
   localparam int unsigned CMD_W = 4;
   localparam int unsigned RI_W  = 4;

   typedef logic [18:0] word_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             S;
   logic [1:0]       mode;
   logic [3:0]       op_code;
   logic [NREG-1:0]  reg_list;
   logic             stall;
   logic             flush;
   logic             out_valid;
   logic [CMD_W-1:0] exe_cmd;
   logic             mem_read, mem_write, wb_en, S_out, B, is_ldr;
   logic [RI_W-1:0]  xfer_reg, xfer_ofs;
   logic             busy;

   word_t sb[$];
   word_t obs_word;
   word_t exp_pop;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_pops   = 0;

   always #5 clk = ~clk;

   ctrl_seq #(
      .NREG  (NREG),
      .CMD_W (CMD_W),
      .RI_W  (RI_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .S         (S),
      .mode      (mode),
      .op_code   (op_code),
      .reg_list  (reg_list),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid),
      .exe_cmd   (exe_cmd),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .wb_en     (wb_en),
      .S_out     (S_out),
      .B         (B),
      .is_ldr    (is_ldr),
      .xfer_reg  (xfer_reg),
      .xfer_ofs  (xfer_ofs),
      .busy      (busy)
   );

   assign obs_word = {out_valid, exe_cmd, mem_read, mem_write, wb_en, S_out, B, is_ldr,
                      xfer_reg, xfer_ofs};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic word_t mkw(input logic v, input logic [3:0] exe, input logic mr,
                                 input logic mw, input logic wb, input logic s, input logic b,
                                 input logic ldr, input logic [3:0] r, input logic [3:0] o);
      return {v, exe, mr, mw, wb, s, b, ldr, r, o};
   endfunction

   function automatic word_t arith(input logic [3:0] exe, input logic wb, input logic s);
      return mkw(1'b1, exe, 1'b0, 1'b0, wb, s, 1'b0, 1'b0, 4'd0, 4'd0);
   endfunction

   function automatic word_t ld(input logic [3:0] r, input logic [3:0] o);
      return mkw(1'b1, ADD_EXE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, r, o);
   endfunction

   function automatic word_t st(input logic [3:0] r, input logic [3:0] o);
      return mkw(1'b1, ADD_EXE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r, o);
   endfunction

   task automatic cyc(input logic iv, input logic s, input logic [1:0] md, input logic [3:0] op,
                      input logic [15:0] rl, input logic stl, input logic fl,
                      input word_t exp_w, input logic exp_busy);
      @(negedge clk);
      in_valid = iv;
      S        = s;
      mode     = md;
      op_code  = op;
      reg_list = rl;
      stall    = stl;
      flush    = fl;
      sb.push_back(exp_w);
      #1 check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
   endtask

   task automatic idle(input word_t exp_w, input logic exp_busy);
      cyc(1'b0, 1'b0, MODE_ARITH, 4'd0, 16'h0000, 1'b0, 1'b0, exp_w, exp_busy);
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            exp_pop = sb.pop_front();
            check_eq($sformatf("word%0d", n_pops), {13'd0, obs_word}, {13'd0, exp_pop});
            n_pops++;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: time limit reached, %0d words still queued", sb.size());
      $fatal(1, "bench time limit");
   end

   initial begin : stim
      word_t nop_w, br_w;
      nop_w = mkw(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      br_w  = mkw(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

      rst_n = 1'b1; in_valid = 1'b0; S = 1'b0; mode = 2'b00; op_code = 4'd0;
      reg_list = '0; stall = 1'b0; flush = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_eq("reset_word", {13'd0, obs_word}, 32'd0);
      check_eq("reset_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Single-cycle decode
      cyc(1'b1, 1'b0, MODE_ARITH, OP_ADD, 16'h0, 1'b0, 1'b0, arith(ADD_EXE, 1'b1, 1'b0), 1'b0);
      cyc(1'b1, 1'b1, MODE_ARITH, OP_ADD, 16'h0, 1'b0, 1'b0, arith(ADD_EXE, 1'b1, 1'b1), 1'b0);
      cyc(1'b1, 1'b1, MODE_ARITH, OP_CMP, 16'h0, 1'b0, 1'b0, arith(SUB_EXE, 1'b0, 1'b1), 1'b0);
      cyc(1'b1, 1'b1, MODE_ARITH, OP_TST, 16'h0, 1'b0, 1'b0, arith(TST_EXE, 1'b0, 1'b1), 1'b0);
      cyc(1'b1, 1'b0, MODE_ARITH, OP_MOV, 16'h0, 1'b0, 1'b0, arith(MOV_EXE, 1'b1, 1'b0), 1'b0);
      cyc(1'b1, 1'b0, MODE_ARITH, OP_EOR, 16'h0, 1'b0, 1'b0, arith(EOR_EXE, 1'b1, 1'b0), 1'b0);
      cyc(1'b1, 1'b1, MODE_ARITH, 4'b0011, 16'h0, 1'b0, 1'b0, nop_w, 1'b0);
      idle(19'd0, 1'b0);
      cyc(1'b1, 1'b1, MODE_MEM, OP_AND, 16'h0, 1'b0, 1'b0, ld(4'd0, 4'd0), 1'b0);
      cyc(1'b1, 1'b0, MODE_MEM, OP_AND, 16'h0, 1'b0, 1'b0, st(4'd0, 4'd0), 1'b0);
      cyc(1'b1, 1'b1, MODE_BRANCH, OP_ADD, 16'h0, 1'b0, 1'b0, br_w, 1'b0);
      cyc(1'b1, 1'b0, MODE_ARITH, OP_ADD, 16'h0, 1'b1, 1'b0, br_w, 1'b0);
      idle(19'd0, 1'b0);

      // Block load 0x8012: beats 1, 4, 15
      cyc(1'b1, 1'b1, MODE_BLOCK, 4'd0, 16'h8012, 1'b0, 1'b0, ld(4'd1, 4'd0), 1'b1);
      idle(ld(4'd4, 4'd1), 1'b1);
      idle(ld(4'd15, 4'd2), 1'b1);
      idle(19'd0, 1'b0);

      // Same load with a two-cycle stall while beat 1 is on the outputs
      cyc(1'b1, 1'b1, MODE_BLOCK, 4'd0, 16'h8012, 1'b0, 1'b0, ld(4'd1, 4'd0), 1'b1);
      cyc(1'b0, 1'b0, MODE_ARITH, 4'd0, 16'h0, 1'b1, 1'b0, ld(4'd1, 4'd0), 1'b1);
      cyc(1'b0, 1'b0, MODE_ARITH, 4'd0, 16'h0, 1'b1, 1'b0, ld(4'd1, 4'd0), 1'b1);
      idle(ld(4'd4, 4'd1), 1'b1);
      idle(ld(4'd15, 4'd2), 1'b1);
      idle(19'd0, 1'b0);

      // Block store 0x00F0 flushed (with stall also high) during its second beat
      cyc(1'b1, 1'b0, MODE_BLOCK, 4'd0, 16'h00F0, 1'b0, 1'b0, st(4'd4, 4'd0), 1'b1);
      idle(st(4'd5, 4'd1), 1'b1);
      cyc(1'b1, 1'b0, MODE_ARITH, OP_ADD, 16'h0, 1'b1, 1'b1, 19'd0, 1'b1);
      idle(19'd0, 1'b0);
      idle(19'd0, 1'b0);

      // Empty and single-bit block lists
      cyc(1'b1, 1'b1, MODE_BLOCK, 4'd0, 16'h0000, 1'b0, 1'b0, nop_w, 1'b0);
      cyc(1'b1, 1'b0, MODE_BLOCK, 4'd0, 16'h0100, 1'b0, 1'b0, st(4'd8, 4'd0), 1'b0);
      idle(19'd0, 1'b0);

      // All-ones list: sixteen beats, offsets 0..15
      cyc(1'b1, 1'b1, MODE_BLOCK, 4'd0, 16'hFFFF, 1'b0, 1'b0, ld(4'd0, 4'd0), 1'b1);
      for (int i = 1; i < 16; i++) begin
         idle(ld(4'(i), 4'(i)), 1'b1);
      end
      idle(19'd0, 1'b0);

      // Asynchronous reset in the middle of a transfer
      cyc(1'b1, 1'b1, MODE_BLOCK, 4'd0, 16'h00F0, 1'b0, 1'b0, ld(4'd4, 4'd0), 1'b1);
      idle(ld(4'd5, 4'd1), 1'b1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_eq("rst_mid_word", {13'd0, obs_word}, 32'd0);
      check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      cyc(1'b1, 1'b0, MODE_ARITH, OP_ADD, 16'h0, 1'b0, 1'b0, arith(ADD_EXE, 1'b1, 1'b0), 1'b0);
      idle(19'd0, 1'b0);
      idle(19'd0, 1'b0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(posedge clk);
      end
      #2 check_eq("sb_drain", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
